core_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32 core. Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file and single shared memory port.
- Consumes decoder opcode one-hot flags and the illegal-instruction flag.
- Produces datapath enables, memory handshake, trap signalling and debug halt/resume control.

---
 rtl/core_ctrl_pkg.sv | 14 +
 rtl/bus_watchdog.sv | 21 ++
 rtl/core_sequencer.sv | 107 ++++++++++
 tb/tb_core_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: sequencer state encoding, PC source and trap cause codes
package core_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP, S_HALTED
  } state_t;
  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_ALU   = 2'd2;
  localparam logic [1:0] PC_SEL_TRAP  = 2'd3;
  localparam logic [1:0] TRAP_CAUSE_ILLEGAL  = 2'd0;
  localparam logic [1:0] TRAP_CAUSE_FETCH_TO = 2'd1;
  localparam logic [1:0] TRAP_CAUSE_DATA_TO  = 2'd2;
  localparam logic [1:0] TRAP_CAUSE_ECALL    = 2'd3;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts unacknowledged request cycles and flags a bus timeout
module bus_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic timeout
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
  localparam logic [W-1:0] SAT  = W'(MEM_TIMEOUT);
  logic [W-1:0] r_count;
  // an ack in the final cycle suppresses the timeout
  assign timeout = active && !ack && r_count == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (!active || ack || timeout) r_count <= '0;
    else if (r_count != SAT) r_count <= r_count + 1'b1;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM
module core_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt_req,
  input  logic       resume_req,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_dfetch,
  input  logic       mem_ack,
  input  logic       invalid_inst,
  input  logic       opcode_load,
  input  logic       opcode_store,
  input  logic       opcode_miscmem,
  input  logic       opcode_opimm,
  input  logic       opcode_op,
  input  logic       opcode_lui,
  input  logic       opcode_auipc,
  input  logic       opcode_branch,
  input  logic       opcode_jal,
  input  logic       opcode_jalr,
  input  logic       opcode_system,
  input  logic       sys_ebreak,
  input  logic       sys_ecall,
  input  logic       branch_taken,
  output logic       ir_we,
  output logic       rf_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       halted
);
  state_t     r_state, w_next;
  logic [1:0] r_cause, w_cause;
  logic       r_br_taken, w_timeout, w_rd_write;
  bus_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (mem_req),
    .ack     (mem_ack),
    .timeout (w_timeout)
  );
  // reset parks the state in FETCH, so gate the request off while rst_n is low
  assign mem_req    = rst_n && (r_state == S_FETCH || r_state == S_MEMORY);
  assign mem_dfetch = r_state == S_MEMORY;
  assign mem_we     = r_state == S_MEMORY && opcode_store;
  assign ir_we      = rst_n && r_state == S_FETCH && mem_ack;
  assign trap       = r_state == S_TRAP;
  assign halted     = r_state == S_HALTED;
  assign pc_we      = r_state == S_WRITEBACK || r_state == S_TRAP;
  assign trap_cause = r_cause;
  assign w_rd_write = (opcode_load || opcode_opimm || opcode_op || opcode_lui || opcode_auipc ||
                       opcode_jal || opcode_jalr || opcode_system) &&
                      !(opcode_store || opcode_branch || opcode_miscmem);
  assign rf_we      = r_state == S_WRITEBACK && w_rd_write;
  assign pc_sel     = r_state == S_TRAP ? PC_SEL_TRAP :
                      r_state != S_WRITEBACK ? PC_SEL_PLUS4 :
                      (opcode_jal || (opcode_branch && r_br_taken)) ? PC_SEL_IMM :
                      opcode_jalr ? PC_SEL_ALU : PC_SEL_PLUS4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= RESET_HALTED ? S_HALTED : S_FETCH;
      r_cause    <= TRAP_CAUSE_ILLEGAL;
      r_br_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      if (r_state == S_EXECUTE) r_br_taken <= branch_taken;
    end
  always_comb begin
    w_next  = r_state;
    w_cause = r_cause;
    case (r_state)
      S_FETCH:
        if (mem_ack) w_next = S_DECODE;
        else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = TRAP_CAUSE_FETCH_TO;
        end
      S_DECODE:
        if (invalid_inst) begin
          w_next  = S_TRAP;
          w_cause = TRAP_CAUSE_ILLEGAL;
        end else if (sys_ebreak) w_next = S_HALTED;
        else if (sys_ecall) begin
          w_next  = S_TRAP;
          w_cause = TRAP_CAUSE_ECALL;
        end else w_next = S_EXECUTE;
      S_EXECUTE: w_next = (opcode_load || opcode_store) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:
        if (mem_ack) w_next = S_WRITEBACK;
        else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = TRAP_CAUSE_DATA_TO;
        end
      S_WRITEBACK, S_TRAP: w_next = halt_req ? S_HALTED : S_FETCH;
      S_HALTED: if (resume_req) w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed checks of sequencing, traps, halt/resume and reset
module tb_core_sequencer;
  localparam logic [10:0] OP_LOAD  = 11'h400, OP_STORE = 11'h200, OP_MISC = 11'h100,
                          OP_OPIMM = 11'h080, OP_OP    = 11'h040, OP_LUI  = 11'h020,
                          OP_AUIPC = 11'h010, OP_BR    = 11'h008, OP_JAL  = 11'h004,
                          OP_JALR  = 11'h002, OP_SYS   = 11'h001;
  logic clk = 1'b0, rst_n = 1'b0;
  logic halt_req = 0, resume_req = 0, mem_ack = 0, invalid_inst = 0;
  logic sys_ebreak = 0, sys_ecall = 0, branch_taken = 0;
  logic [10:0] op = '0;
  logic mem_req, mem_we, mem_dfetch, ir_we, rf_we, pc_we, trap, halted;
  logic [1:0] pc_sel, trap_cause;
  logic h_mem_req, h_mem_we, h_mem_dfetch, h_ir_we, h_rf_we, h_pc_we, h_trap, h_halted;
  logic [1:0] h_pc_sel, h_trap_cause;
  int errs = 0, n = 0;
  always #5 clk = ~clk;
  core_sequencer #(.MEM_TIMEOUT(8), .RESET_HALTED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .resume_req(resume_req),
    .mem_req(mem_req), .mem_we(mem_we), .mem_dfetch(mem_dfetch), .mem_ack(mem_ack),
    .invalid_inst(invalid_inst), .opcode_load(op[10]), .opcode_store(op[9]),
    .opcode_miscmem(op[8]), .opcode_opimm(op[7]), .opcode_op(op[6]), .opcode_lui(op[5]),
    .opcode_auipc(op[4]), .opcode_branch(op[3]), .opcode_jal(op[2]), .opcode_jalr(op[1]),
    .opcode_system(op[0]), .sys_ebreak(sys_ebreak), .sys_ecall(sys_ecall),
    .branch_taken(branch_taken), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause), .halted(halted)
  );
  core_sequencer #(.MEM_TIMEOUT(8), .RESET_HALTED(1'b1)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .resume_req(resume_req),
    .mem_req(h_mem_req), .mem_we(h_mem_we), .mem_dfetch(h_mem_dfetch), .mem_ack(mem_ack),
    .invalid_inst(invalid_inst), .opcode_load(op[10]), .opcode_store(op[9]),
    .opcode_miscmem(op[8]), .opcode_opimm(op[7]), .opcode_op(op[6]), .opcode_lui(op[5]),
    .opcode_auipc(op[4]), .opcode_branch(op[3]), .opcode_jal(op[2]), .opcode_jalr(op[1]),
    .opcode_system(op[0]), .sys_ebreak(sys_ebreak), .sys_ecall(sys_ecall),
    .branch_taken(branch_taken), .ir_we(h_ir_we), .rf_we(h_rf_we), .pc_we(h_pc_we),
    .pc_sel(h_pc_sel), .trap(h_trap), .trap_cause(h_trap_cause), .halted(h_halted)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_ack = 0;
      #1;
      chk("fetch_wait_req", mem_req, 1);
      chk("fetch_wait_irwe", ir_we, 0);
      go();
    end
    mem_ack = 1;
    #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_dfetch", mem_dfetch, 0);
    chk("fetch_we", mem_we, 0);
    chk("fetch_irwe", ir_we, 1);
    go();
    mem_ack = 0;
  endtask
  task automatic alu_instr(input string tag, input logic [10:0] ops, input logic bt,
                           input logic exp_rf, input logic [1:0] exp_sel);
    op = ops;
    fetch(0);
    #1;
    chk({tag, "_dec_req"}, mem_req, 0);
    chk({tag, "_dec_pcwe"}, pc_we, 0);
    go();
    branch_taken = bt;
    #1;
    chk({tag, "_ex_rfwe"}, rf_we, 0);
    go();
    branch_taken = 0;
    #1;
    chk({tag, "_wb_rfwe"}, rf_we, exp_rf);
    chk({tag, "_wb_pcwe"}, pc_we, 1);
    chk({tag, "_wb_pcsel"}, pc_sel, exp_sel);
    go();
    chk({tag, "_next_req"}, mem_req, 1);
  endtask
  initial begin
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_irwe", ir_we, 0);
    chk("rst_pcwe", pc_we, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_halted", halted, 0);
    chk("rst_h_halted", h_halted, 1);
    chk("rst_h_req", h_mem_req, 0);
    rst_n = 1;
    alu_instr("addi", OP_OPIMM, 0, 1, 0);
    alu_instr("beq_t", OP_BR, 1, 0, 1);
    alu_instr("beq_nt", OP_BR, 0, 0, 0);
    alu_instr("jal", OP_JAL, 0, 1, 1);
    alu_instr("jalr", OP_JALR, 0, 1, 2);
    alu_instr("fence", OP_MISC, 0, 0, 0);
    alu_instr("csr", OP_SYS, 0, 1, 0);
    alu_instr("lui", OP_LUI, 0, 1, 0);
    alu_instr("add", OP_OP, 0, 1, 0);
    alu_instr("auipc", OP_AUIPC, 0, 1, 0);
    chk("h_still_halted", h_halted, 1);
    op = OP_STORE;
    fetch(1);
    go();
    go();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      chk("sw_req", mem_req, 1);
      chk("sw_we", mem_we, 1);
      chk("sw_dfetch", mem_dfetch, 1);
      go();
    end
    mem_ack = 0;
    #1;
    chk("sw_wb_rfwe", rf_we, 0);
    chk("sw_wb_pcwe", pc_we, 1);
    go();
    chk("sw_next_dfetch", mem_dfetch, 0);
    chk("sw_next_we", mem_we, 0);
    op = OP_SYS;
    sys_ecall = 1;
    fetch(0);
    go();
    chk("ecall_trap", trap, 1);
    chk("ecall_cause", trap_cause, 3);
    chk("ecall_pcsel", pc_sel, 3);
    chk("ecall_pcwe", pc_we, 1);
    chk("ecall_rfwe", rf_we, 0);
    sys_ecall = 0;
    go();
    chk("ecall_trap_end", trap, 0);
    chk("ecall_cause_held", trap_cause, 3);
    op = '0;
    invalid_inst = 1;
    fetch(0);
    chk("ill_dec_trap", trap, 0);
    go();
    chk("ill_trap", trap, 1);
    chk("ill_cause", trap_cause, 0);
    chk("ill_pcsel", pc_sel, 3);
    chk("ill_rfwe", rf_we, 0);
    invalid_inst = 0;
    go();
    chk("ill_next_req", mem_req, 1);
    op = OP_OPIMM;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fto_req", mem_req, 1);
      chk("fto_trap", trap, 0);
      go();
    end
    chk("fto_trap_fire", trap, 1);
    chk("fto_cause", trap_cause, 1);
    go();
    for (int i = 0; i < 8; i++) begin
      mem_ack = (i == 7);
      #1;
      chk("fack8_req", mem_req, 1);
      go();
    end
    mem_ack = 0;
    #1;
    chk("fack8_no_trap", trap, 0);
    chk("fack8_dec_req", mem_req, 0);
    go();
    go();
    chk("fack8_wb_rfwe", rf_we, 1);
    go();
    op = OP_LOAD;
    fetch(0);
    go();
    go();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("dto_dfetch", mem_dfetch, 1);
      chk("dto_we", mem_we, 0);
      go();
    end
    chk("dto_trap", trap, 1);
    chk("dto_cause", trap_cause, 2);
    go();
    fetch(0);
    halt_req = 1;
    go();
    go();
    #1;
    chk("hmem_req", mem_req, 1);
    chk("hmem_not_halted", halted, 0);
    go();
    mem_ack = 1;
    #1;
    go();
    mem_ack = 0;
    #1;
    chk("hmem_wb_rfwe", rf_we, 1);
    chk("hmem_wb_halted", halted, 0);
    go();
    chk("hmem_halted", halted, 1);
    chk("hmem_halt_req", mem_req, 0);
    halt_req = 0;
    go();
    chk("hmem_stays", halted, 1);
    halt_req = 1;
    resume_req = 1;
    go();
    halt_req = 0;
    resume_req = 0;
    chk("resume_wins", halted, 0);
    chk("resume_req_on", mem_req, 1);
    op = OP_SYS;
    sys_ebreak = 1;
    fetch(0);
    go();
    sys_ebreak = 0;
    #1;
    chk("ebreak_halted", halted, 1);
    chk("ebreak_pcwe", pc_we, 0);
    chk("ebreak_trap", trap, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0];
      #1;
      chk("halt_no_req", mem_req, 0);
      chk("halt_no_irwe", ir_we, 0);
      chk("halt_level", halted, 1);
      go();
    end
    mem_ack = 0;
    resume_req = 1;
    go();
    resume_req = 0;
    chk("ebreak_resume", halted, 0);
    chk("ebreak_resume_req", mem_req, 1);
    op = OP_STORE;
    fetch(0);
    go();
    go();
    #1;
    chk("rmem_req", mem_req, 1);
    chk("rmem_we", mem_we, 1);
    #2;
    rst_n = 0;
    #1;
    chk("rmem_req_drop", mem_req, 0);
    chk("rmem_we_drop", mem_we, 0);
    chk("rmem_dfetch_drop", mem_dfetch, 0);
    chk("rmem_cause_clr", trap_cause, 0);
    chk("rmem_h_halted", h_halted, 1);
    #2;
    rst_n = 1;
    #1;
    chk("rel_req", mem_req, 1);
    chk("rel_dfetch", mem_dfetch, 0);
    chk("rel_halted", halted, 0);
    go();
    chk("rel_fetch_hold", mem_req, 1);
    chk("rel_cause", trap_cause, 0);
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
